// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array edge queues.
// Holds the drain FSM state enum and counter/index width helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    STREAM,
    DONE
  } drain_state_t;

  localparam int unsigned DRAIN_N = 8;
  localparam int unsigned CNT_W   = $clog2(DRAIN_N + 1);
  localparam int unsigned IDX_W   = $clog2(DRAIN_N * DRAIN_N);

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/drain_column_buffer.sv
// One column of the drain buffer: N-deep store, write counter, full flag.
// Ports: clk_i/rstn_i, clear_i, wr_en_i/wr_data_i, rd_row_i -> rd_data_o, full_o, drop_o.
module drain_column_buffer
  import systolic_pkg::*;
#(
  parameter  int unsigned N          = 8,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned CW         = cnt_w(N),
  localparam int unsigned RW         = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [RW-1:0]         rd_row_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  drop_o
);

  logic [DATA_WIDTH-1:0] mem_q [N];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_ok;

  assign full_o    = (cnt_q == CW'(N));
  assign wr_ok     = wr_en_i && !full_o;
  assign drop_o    = wr_en_i && full_o;
  assign rd_data_o = mem_q[rd_row_i];

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wr_ok) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; a fresh capture overwrites every row.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[cnt_q[RW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/south_output_drain_queue.sv
// Captures de-skewed south-edge results per column, then streams them row-major.
// Ports: clk_i, rstn_i, collect_start_i, south_i/south_valid_i, result_* (valid/ready),
// collect_done_o, drain_complete_o, overflow_o, checksum_o. Macro: DRAIN_CHECKSUM_EN.
module south_output_drain_queue
  import systolic_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  collect_start_i,
  input  logic [DATA_WIDTH-1:0] south_i [N],
  input  logic [N-1:0]          south_valid_i,
  output logic [DATA_WIDTH-1:0] result_data_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  result_last_o,
  output logic                  collect_done_o,
  output logic                  drain_complete_o,
  output logic                  overflow_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  localparam int unsigned IW  = idx_w(N);
  localparam int unsigned RW  = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
  localparam logic [IW-1:0] N_IDX    = IW'(N);

  drain_state_t          state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, rd_idx;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  drained_q, drained_d;
  logic                  start_ok, collecting, accept, is_last;
  logic [N-1:0]          full, drop;
  logic [DATA_WIDTH-1:0] col_rd [N];
  logic [RW-1:0]         rd_row, rd_col;

  assign start_ok   = collect_start_i &&
                      (state_q == IDLE || state_q == DONE);
  assign collecting = (state_q == COLLECT);
  assign accept     = valid_q && result_ready_i;
  assign is_last    = (idx_q == LAST_IDX);

  // Look one word ahead on acceptance so the next word lands the following cycle.
  assign rd_idx = accept ? idx_q + 1'b1 : idx_q;
  assign rd_row = RW'(rd_idx / N_IDX);
  assign rd_col = RW'(rd_idx % N_IDX);

  for (genvar c = 0; c < N; c++) begin : g_col
    drain_column_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_col (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .clear_i   (start_ok),
      .wr_en_i   (collecting && south_valid_i[c]),
      .wr_data_i (south_i[c]),
      .rd_row_i  (rd_row),
      .rd_data_o (col_rd[c]),
      .full_o    (full[c]),
      .drop_o    (drop[c])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    drained_d = drained_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d   = COLLECT;
          idx_d     = '0;
          ovf_d     = 1'b0;
          drained_d = 1'b0;
        end
      end
      COLLECT: begin
        if (|drop) ovf_d = 1'b1;
        if (&full) state_d = STREAM;
      end
      STREAM: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = col_rd[rd_col];
        end else if (accept) begin
          if (is_last) begin
            valid_d   = 1'b0;
            state_d   = DONE;
            drained_d = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = col_rd[rd_col];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      drained_q <= drained_d;
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] ck_q, ck_d;

  always_comb begin
    ck_d = ck_q;
    if (start_ok) begin
      ck_d = '0;
    end else if (accept) begin
      ck_d = ck_q ^ data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ck_q <= '0;
    end else begin
      ck_q <= ck_d;
    end
  end

  assign checksum_o = ck_q;
`else
  assign checksum_o = '0;
`endif

  assign result_data_o    = data_q;
  assign result_valid_o   = valid_q;
  assign result_last_o    = valid_q && is_last;
  assign collect_done_o   = &full;
  assign drain_complete_o = drained_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_south_output_drain_queue.sv
// Randomized scoreboard bench for south_output_drain_queue (N=4, 32-bit).
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_south_output_drain_queue;
  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] south [N];
  logic [N-1:0]  svalid = '0;
  logic [DW-1:0] rdata, cksum;
  logic          rvalid, rlast, cdone, dcomp, ovf;

  int            tests = 0;
  int            fails = 0;
  exp_t          exp_q[$];
  int            acc_cnt = 0;
  logic [DW-1:0] exp_ck = '0;
  int            ready_mode = 0;
  int            rpat = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;
  logic [DW-1:0] model [N][N];

  always #5 clk = ~clk;

  south_output_drain_queue #(
    .N          (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .collect_start_i  (start),
    .south_i          (south),
    .south_valid_i    (svalid),
    .result_data_o    (rdata),
    .result_valid_o   (rvalid),
    .result_ready_i   (ready),
    .result_last_o    (rlast),
    .collect_done_o   (cdone),
    .drain_complete_o (dcomp),
    .overflow_o       (ovf),
    .checksum_o       (cksum)
  );

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, expv);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: begin
          ready = (rpat == 0 || rpat == 3);
          rpat  = (rpat + 1) % 4;
        end
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 32'(rvalid), 32'd1);
        check("stall_data", rdata, stall_d);
        check("stall_last", 32'(rlast), 32'(stall_l));
      end
      if (rvalid && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got 0x%08h required none", rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", rdata, e.d);
          check("last", 32'(rlast), 32'(e.l));
          exp_ck = exp_ck ^ e.d;
        end
        acc_cnt++;
        stall_q = 1'b0;
      end else if (rvalid) begin
        stall_q = 1'b1;
        stall_d = rdata;
        stall_l = rlast;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] word(input int pat, input int r, input int c);
    case (pat)
      0:       return DW'(16 * r + c);
      1:       return DW'(1 + r * N + c);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    exp_ck = '0;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_after_start", 32'(cdone), 32'd0);
    check("ovf_after_start", 32'(ovf), 32'd0);
    check("drain_after_start", 32'(dcomp), 32'd0);
  endtask

  // mode 0 aligned, 1 skewed by column, 2 random gaps; ovf_col >= 0 adds a 5th word.
  task automatic run_collect(input int mode, input int pat, input int ovf_col);
    int len [N];
    int ptr [N];
    logic [N-1:0] v;
    int cyc;
    bit all_in, done_m, ok;
    for (int c = 0; c < N; c++) begin
      len[c] = N + ((c == ovf_col) ? 1 : 0);
      ptr[c] = 0;
    end
    cyc = 0;
    forever begin
      all_in = 1'b1;
      done_m = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (ptr[c] < len[c]) all_in = 1'b0;
        if (ptr[c] < N) done_m = 1'b0;
      end
      if (all_in) break;
      check("collect_done_early", 32'(cdone), 32'(done_m));
      v = '0;
      for (int c = 0; c < N; c++) begin
        if (ptr[c] < len[c]) begin
          case (mode)
            0:       ok = 1'b1;
            1:       ok = (cyc >= c);
            default: ok = 1'($urandom_range(0, 1));
          endcase
          if (ovf_col >= 0 && c != ovf_col && ptr[c] == N - 1 &&
              ptr[ovf_col] < len[ovf_col]) ok = 1'b0;
          if (ok) begin
            v[c] = 1'b1;
            if (ptr[c] < N) begin
              south[c] = word(pat, ptr[c], c);
              model[ptr[c]][c] = south[c];
            end else begin
              south[c] = $urandom;
            end
          end
        end
      end
      svalid = v;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) if (v[c]) ptr[c]++;
      cyc++;
      if (cyc > 200) begin
        tests++;
        fails++;
        $display("FAIL collect_timeout: got %0d cycles required <= 200", cyc);
        break;
      end
    end
    svalid = '0;
    check("collect_done", 32'(cdone), 32'd1);
    check("overflow", 32'(ovf), 32'(ovf_col >= 0));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back('{model[r][c], (r == N - 1 && c == N - 1)});
  endtask

  task automatic wait_drain(input int base);
    int n;
    n = 0;
    while (!dcomp && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_complete", 32'(dcomp), 32'd1);
    check("valid_after_done", 32'(rvalid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("accept_count", 32'(acc_cnt - base), 32'(N * N));
`ifdef DRAIN_CHECKSUM_EN
    check("checksum", cksum, exp_ck);
`else
    check("checksum_off", cksum, 32'd0);
`endif
  endtask

  task automatic reset_checks();
    check("rst_data", rdata, 32'd0);
    check("rst_valid", 32'(rvalid), 32'd0);
    check("rst_last", 32'(rlast), 32'd0);
    check("rst_done", 32'(cdone), 32'd0);
    check("rst_drain", 32'(dcomp), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_cksum", cksum, 32'd0);
  endtask

  initial begin
    int base, n;
    for (int c = 0; c < N; c++) south[c] = '0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // aligned
    ready_mode = 0;
    base = acc_cnt;
    do_start();
    run_collect(0, 0, -1);
    wait_drain(base);
`ifdef DRAIN_CHECKSUM_EN
    check("cksum_case1", cksum, 32'h0);
`endif

    // skewed
    base = acc_cnt;
    do_start();
    run_collect(1, 0, -1);
    wait_drain(base);

    // backpressure, with an ignored start pulse mid-stream
    ready_mode = 1;
    rpat = 0;
    base = acc_cnt;
    do_start();
    run_collect(0, 0, -1);
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_ignored_done", 32'(cdone), 32'd1);
    wait_drain(base);

    // overflow on column 2
    ready_mode = 0;
    base = acc_cnt;
    do_start();
    run_collect(0, 0, 2);
    wait_drain(base);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // values 1..16
    ready_mode = 2;
    base = acc_cnt;
    do_start();
    run_collect(2, 1, -1);
    wait_drain(base);
`ifdef DRAIN_CHECKSUM_EN
    check("cksum_1_16", cksum, 32'h10);
`endif

    // random
    for (int i = 0; i < 4; i++) begin
      base = acc_cnt;
      do_start();
      run_collect(2, 2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1);
      wait_drain(base);
    end

    // reset mid-stream after 7 accepts
    base = acc_cnt;
    do_start();
    run_collect(2, 2, -1);
    n = 0;
    while (acc_cnt - base < 7 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accepts_before_reset", 32'(acc_cnt - base), 32'd7);
    #1 rstn = 1'b0;
    #1;
    reset_checks();
    exp_q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    ready_mode = 0;
    base = acc_cnt;
    do_start();
    run_collect(0, 0, -1);
    wait_drain(base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
